// File: rtl/interp2_poly_fir.sv
// Polyphase interpolate-by-2 FIR with signed +/-1 taps, valid/ready on both sides.
// Optional macro INTERP2_ROUND_EN switches tap pre-scaling from truncation to round-half-up.
module interp2_poly_fir #(
    parameter int               IN_W     = 15,
    parameter int               OUT_W    = 18,
    parameter int               NTAPS    = 4,
    parameter int               SHIFT    = 1,
    parameter logic [NTAPS-1:0] PH0_SIGN = '0,
    parameter logic [NTAPS-1:0] PH1_SIGN = NTAPS'(4'b0110)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  xin,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    output logic signed [OUT_W-1:0] out,
    output logic                    out_phase,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef logic [NTAPS-1:0][IN_W-1:0] taps_t;

`ifdef INTERP2_ROUND_EN
    localparam logic signed [IN_W:0] RND = (IN_W + 1)'((2 ** SHIFT) / 2);
`endif

    function automatic logic signed [OUT_W-1:0] scale_tap(input logic signed [IN_W-1:0] t);
`ifdef INTERP2_ROUND_EN
        logic signed [IN_W:0] wide;
        // One guard bit keeps the rounding offset from wrapping at the positive limit.
        wide = {t[IN_W-1], t} + RND;
        return OUT_W'(wide >>> SHIFT);
`else
        logic signed [IN_W-1:0] sh;
        sh = t >>> SHIFT;
        return OUT_W'(sh);
`endif
    endfunction

    function automatic logic signed [OUT_W-1:0] poly_sum(input logic [NTAPS-1:0] sgn,
                                                         input taps_t taps);
        logic signed [OUT_W-1:0] acc;
        // NOTE: blocking assignments are correct here; acc is a combinational
        // accumulator rebuilt on every call, never a stored state element.
        acc = '0;
        for (int i = 0; i < NTAPS; i++) begin
            if (sgn[i]) acc = acc - scale_tap(taps[i]);
            else        acc = acc + scale_tap(taps[i]);
        end
        return acc;
    endfunction

    taps_t dly;
    taps_t new_taps;
    logic  mode_q;
    logic  last;
    logic  accept;
    logic  advance;

    // new_taps[0] is the incoming sample; it is also the next history contents.
    assign new_taps = {dly[NTAPS-2:0], xin};

    assign last     = mode_q | out_phase;
    assign in_ready = !out_valid | (out_ready & last);
    assign accept   = in_valid & in_ready;
    assign advance  = out_valid & out_ready & !out_phase & !mode_q;

    always_ff @(posedge clk) begin
        // NOTE: every register, history included, is cleared on reset so a
        // restarted stream never mixes in samples from before the reset.
        if (rst) begin
            dly       <= '0;
            out       <= '0;
            out_phase <= 1'b0;
            out_valid <= 1'b0;
            mode_q    <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments so every register samples
            // pre-edge values, independent of statement order.
            dly       <= new_taps;
            mode_q    <= mode;
            out       <= poly_sum(mode ? PH1_SIGN : PH0_SIGN, new_taps);
            out_phase <= mode;
            out_valid <= 1'b1;
        end else if (advance) begin
            out       <= poly_sum(PH1_SIGN, dly);
            out_phase <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_interp2_poly_fir.sv
// Self-checking bench for interp2_poly_fir: directed scenarios plus random traffic
// compared against an integer scoreboard model of the filter.
module tb_interp2_poly_fir;

    localparam int IN_W  = 15;
    localparam int OUT_W = 18;
    localparam int NTAPS = 4;
    localparam int SHIFT = 1;

    // Coefficients per phase, index 0 applies to the newest sample.
    localparam int C0 [NTAPS] = '{1, 1, 1, 1};
    localparam int C1 [NTAPS] = '{1, -1, -1, 1};

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [IN_W-1:0]  xin;
    logic                    in_valid;
    logic                    in_ready;
    logic                    mode;
    logic signed [OUT_W-1:0] out;
    logic                    out_phase;
    logic                    out_valid;
    logic                    out_ready;

    interp2_poly_fir #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .NTAPS(NTAPS),
        .SHIFT(SHIFT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .xin      (xin),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .out      (out),
        .out_phase(out_phase),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   val;
        logic ph;
        logic last;
    } exp_t;

    exp_t sb[$];
    int   hist[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int tapv(input int t);
        int d;
        d = 1 << SHIFT;
`ifdef INTERP2_ROUND_EN
        return floor_div(t + d / 2, d);
`else
        return floor_div(t, d);
`endif
    endfunction

    function automatic int model_sum(input int ph);
        int acc;
        acc = 0;
        for (int i = 0; i < NTAPS; i++)
            acc += (ph == 0 ? C0[i] : C1[i]) * tapv(hist[i]);
        return acc;
    endfunction

    function automatic int rand_sample();
        return int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
    endfunction

    task automatic model_clear();
        sb.delete();
        hist.delete();
        for (int i = 0; i < NTAPS; i++) hist.push_back(0);
    endtask

    // One clock: drive at negedge, check against the scoreboard, update the model.
    task automatic cycle(input logic iv, input int x, input logic m, input logic ordy,
                         output logic acc);
        logic exp_rdy;
        logic signed [OUT_W-1:0] ev;
        exp_t item;
        @(negedge clk);
        in_valid  = iv;
        xin       = x[IN_W-1:0];
        mode      = m;
        out_ready = ordy;
        #1;
        n_checks++;
        if (out_valid !== (sb.size() != 0)) begin
            n_fail++;
            $display("FAIL out_valid: got %b expected %b", out_valid, sb.size() != 0);
        end
        exp_rdy = (sb.size() == 0) || (ordy && sb[0].last);
        n_checks++;
        if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
        end
        if (out_valid === 1'b1 && ordy && sb.size() != 0) begin
            item = sb.pop_front();
            ev = OUT_W'(item.val);
            n_checks++;
            if (out !== ev || out_phase !== item.ph) begin
                n_fail++;
                $display("FAIL output: got %0d ph %b expected %0d ph %b",
                         out, out_phase, ev, item.ph);
            end
        end
        acc = iv && (in_ready === 1'b1);
        if (acc) begin
            hist.push_front(x);
            void'(hist.pop_back());
            if (m == 1'b0) begin
                sb.push_back('{model_sum(0), 1'b0, 1'b0});
                sb.push_back('{model_sum(1), 1'b1, 1'b1});
            end else begin
                sb.push_back('{model_sum(1), 1'b1, 1'b1});
            end
        end
    endtask

    task automatic send(input int x, input logic m);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) cycle(1'b1, x, m, 1'b1, acc);
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_timeout: got accepted=0 expected accepted=1");
        end
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && sb.size() != 0; i++) cycle(1'b0, 0, 1'b0, 1'b1, acc);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; xin = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out !== '0 || out_phase !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b out=%0d ph=%b rdy=%b expected 0 0 0 1",
                     out_valid, out, out_phase, in_ready);
        end
    endtask

    task automatic test_interp_basic();
        logic acc;
        do_reset();
        cycle(1'b1, 100, 1'b0, 1'b1, acc);
        cycle(1'b0, 0, 1'b0, 1'b1, acc);
        n_checks++;
        if (out !== 18'sd50 || out_phase !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL interp_ph0: got out=%0d ph=%b rdy=%b expected 50 0 0",
                     out, out_phase, in_ready);
        end
        cycle(1'b0, 0, 1'b0, 1'b1, acc);
        n_checks++;
        if (out !== 18'sd50 || out_phase !== 1'b1) begin
            n_fail++;
            $display("FAIL interp_ph1: got out=%0d ph=%b expected 50 1", out, out_phase);
        end
        drain();
    endtask

    task automatic test_four_hundreds();
        logic acc;
        do_reset();
        for (int i = 0; i < 4; i++) send(100, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b1, acc);
        n_checks++;
        if (out !== 18'sd200 || out_phase !== 1'b0) begin
            n_fail++;
            $display("FAIL four_ph0: got out=%0d ph=%b expected 200 0", out, out_phase);
        end
        cycle(1'b0, 0, 1'b0, 1'b1, acc);
        n_checks++;
        if (out !== 18'sd0 || out_phase !== 1'b1) begin
            n_fail++;
            $display("FAIL four_ph1: got out=%0d ph=%b expected 0 1", out, out_phase);
        end
        drain();
    endtask

    task automatic test_negative_mode1();
        logic acc;
        logic signed [OUT_W-1:0] ev;
`ifdef INTERP2_ROUND_EN
        ev = -18'sd1;
`else
        ev = -18'sd2;
`endif
        do_reset();
        cycle(1'b1, -3, 1'b1, 1'b1, acc);
        cycle(1'b0, 0, 1'b1, 1'b1, acc);
        n_checks++;
        if (out !== ev || out_phase !== 1'b1) begin
            n_fail++;
            $display("FAIL neg_mode1: got out=%0d ph=%b expected %0d 1", out, out_phase, ev);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic acc;
        logic signed [OUT_W-1:0] held;
        do_reset();
        cycle(1'b1, 300, 1'b0, 1'b0, acc);
        cycle(1'b1, 0, 1'b0, 1'b0, acc);
        held = out;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, rand_sample(), 1'b0, 1'b0, acc);
            n_checks++;
            if (out !== held || out_phase !== 1'b0 || in_ready !== 1'b0 || acc) begin
                n_fail++;
                $display("FAIL backpressure: got out=%0d ph=%b rdy=%b expected %0d 0 0",
                         out, out_phase, in_ready, held);
            end
        end
        drain();
        send(-500, 1'b0);
        drain();
    endtask

    task automatic test_stream_mode1();
        logic acc;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 10 * i, 1'b1, 1'b1, acc);
            n_checks++;
            if (!acc) begin
                n_fail++;
                $display("FAIL stream_ready: got in_ready=%b expected 1", in_ready);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic acc;
        do_reset();
        cycle(1'b1, 100, 1'b0, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out !== 18'sd50 || out_phase !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got v=%b out=%0d expected 1 50", out_valid, out);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_post: got v=%b out=%0d expected 0 0", out_valid, out);
        end
        rst = 1'b0;
        model_clear();
        cycle(1'b1, 100, 1'b0, 1'b1, acc);
        cycle(1'b0, 0, 1'b0, 1'b1, acc);
        n_checks++;
        if (out !== 18'sd50 || out_phase !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_hist: got out=%0d ph=%b expected 50 0", out, out_phase);
        end
        drain();
    endtask

    task automatic test_random();
        logic acc;
        do_reset();
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 3) != 0), rand_sample(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), acc);
        drain();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; xin = '0;
        model_clear();
        test_reset();
        test_interp_basic();
        test_four_hundreds();
        test_negative_mode1();
        test_backpressure();
        test_stream_mode1();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
